// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types for the register-transfer sequencer: command opcodes, FSM state codes, index range helper.
// State codes are plain constants so legacy decode logic can compare against them directly.
package reg_seq_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MOVE   = 2'b00,
        OP_SWAP   = 2'b01,
        OP_READ_A = 2'b10,
        OP_LOAD   = 2'b11
    } op_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD0  = 3'd1;
    localparam state_t ST_RD1  = 3'd2;
    localparam state_t ST_WR0  = 3'd3;
    localparam state_t ST_WR1  = 3'd4;
    localparam state_t ST_RA   = 3'd5;

    function automatic logic sel_valid(input int unsigned idx, input int unsigned nregs);
        return idx < nregs;
    endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Command handshake plus register-bank control/data bundle between decode, sequencer and register file.
// master = sequencer side; slave = decode stage and register bank side.
interface reg_bus_sequencer_if #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) ();
    import reg_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    op_t              req_op;
    logic [SEL_W-1:0] req_src;
    logic [SEL_W-1:0] req_dst;
    logic [WIDTH-1:0] req_imm;
    logic [NREGS-1:0] en_a;
    logic [NREGS-1:0] en_b;
    logic [NREGS-1:0] s;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] bus_b;
    logic             done;
    logic             err;

    modport master (
        input  req_valid, req_op, req_src, req_dst, req_imm, bus_b,
        output req_ready, en_a, en_b, s, wr_data, done, err
    );

    modport slave (
        output req_valid, req_op, req_src, req_dst, req_imm, bus_b,
        input  req_ready, en_a, en_b, s, wr_data, done, err
    );

endinterface

// File: rtl/reg_bus_sequencer_decoder.sv
// Purpose: index + enable -> one-hot register select; all-zero when the index is outside the bank.
// Latency: combinational.
// Backpressure: none.
module reg_select_decoder #(
    parameter int NREGS = 8,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (idx == SEL_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Purpose: sequences MOVE/SWAP/LOAD/READ_A over a tristate register bank via one-hot enables and store strobes.
// Latency: done in cycle 1 (LOAD, READ_A), 2 (MOVE) or 4 (SWAP) after accept; one IDLE cycle between commands.
// Backpressure: req_ready high only in IDLE; no queuing, one command in flight.
module reg_bus_sequencer
    import reg_seq_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    reg_bus_sequencer_if.master bus
);

    state_t           state, state_n;
    op_t              op_q;
    logic [SEL_W-1:0] src_q, dst_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] tmp0, tmp1, tmp0_n;

    logic             accept;
    op_t              cur_op;
    logic [SEL_W-1:0] cur_src, cur_dst, b_idx;
    logic [WIDTH-1:0] cur_imm;

    logic             a_go, b_go, s_go;
    logic [NREGS-1:0] en_a_n, en_b_n, s_n;
    logic [WIDTH-1:0] wr_data_n;
    logic             done_n, err_n, src_bad, dst_bad;

    logic [NREGS-1:0] en_a_q, en_b_q, s_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             done_q, err_q;

    assign accept = (state == ST_IDLE) && bus.req_valid;

    // On the accept edge the command fields are used straight from the request so the first step needs no bubble.
    always_comb begin
        cur_op  = accept ? bus.req_op  : op_q;
        cur_src = accept ? bus.req_src : src_q;
        cur_dst = accept ? bus.req_dst : dst_q;
        cur_imm = accept ? bus.req_imm : imm_q;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cur_op)
                        OP_MOVE:   state_n = ST_RD0;
                        OP_SWAP:   state_n = ST_RD0;
                        OP_LOAD:   state_n = ST_WR0;
                        OP_READ_A: state_n = ST_RA;
                        default:   state_n = ST_IDLE;
                    endcase
                end
            end
            ST_RD0:  state_n = (cur_op == OP_SWAP) ? ST_RD1 : ST_WR0;
            ST_RD1:  state_n = ST_WR0;
            ST_WR0:  state_n = (cur_op == OP_SWAP) ? ST_WR1 : ST_IDLE;
            ST_WR1:  state_n = ST_IDLE;
            ST_RA:   state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign a_go  = (state_n == ST_RA);
    assign b_go  = (state_n == ST_RD0) || (state_n == ST_RD1) ||
                   (state_n == ST_WR0) || (state_n == ST_WR1);
    assign s_go  = (state_n == ST_WR0) || (state_n == ST_WR1);
    assign b_idx = ((state_n == ST_RD0) || (state_n == ST_WR1)) ? cur_src : cur_dst;

    reg_select_decoder #(.NREGS(NREGS), .SEL_W(SEL_W)) u_dec_a (
        .idx    (cur_src),
        .en     (a_go),
        .onehot (en_a_n)
    );

    reg_select_decoder #(.NREGS(NREGS), .SEL_W(SEL_W)) u_dec_b (
        .idx    (b_idx),
        .en     (b_go),
        .onehot (en_b_n)
    );

    reg_select_decoder #(.NREGS(NREGS), .SEL_W(SEL_W)) u_dec_s (
        .idx    (b_idx),
        .en     (s_go),
        .onehot (s_n)
    );

    // MOVE goes RD0 -> WR0 directly, so its write data is the value being captured on this very edge.
    assign tmp0_n = (state == ST_RD0) ? bus.bus_b : tmp0;

    always_comb begin
        wr_data_n = '0;
        if (state_n == ST_WR0) begin
            wr_data_n = (cur_op == OP_LOAD) ? cur_imm : tmp0_n;
        end else if (state_n == ST_WR1) begin
            wr_data_n = tmp1;
        end
    end

    assign src_bad = !sel_valid(32'(cur_src), NREGS);
    assign dst_bad = !sel_valid(32'(cur_dst), NREGS);
    assign done_n  = (state_n == ST_RA) || (state_n == ST_WR1) ||
                     ((state_n == ST_WR0) && (cur_op != OP_SWAP));

    always_comb begin
        err_n = 1'b0;
        if (done_n) begin
            case (cur_op)
                OP_MOVE:   err_n = src_bad || dst_bad;
                OP_SWAP:   err_n = src_bad || dst_bad;
                OP_LOAD:   err_n = dst_bad;
                OP_READ_A: err_n = src_bad;
                default:   err_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MOVE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            tmp0      <= '0;
            tmp1      <= '0;
            en_a_q    <= '0;
            en_b_q    <= '0;
            s_q       <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= bus.req_op;
                src_q <= bus.req_src;
                dst_q <= bus.req_dst;
                imm_q <= bus.req_imm;
            end
            tmp0 <= tmp0_n;
            if (state == ST_RD1) begin
                tmp1 <= bus.bus_b;
            end
            en_a_q    <= en_a_n;
            en_b_q    <= en_b_n;
            s_q       <= s_n;
            wr_data_q <= wr_data_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.en_a      = en_a_q;
    assign bus.en_b      = en_b_q;
    assign bus.s         = s_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
